// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: samples PS2_CLK/PS2_DATA and returns each 11-bit frame as a byte plus error pulses.
// Define PS2_RX_FILTER_EN to add a FILT_LEN-cycle stability filter on the synchronised PS2_CLK.
module ps2_rx #(
    parameter int TIMEOUT_CYC = 100_000,
    parameter int FILT_LEN    = 8
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       rx_inhibit,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy,
    output logic [1:0] dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    if (FILT_LEN < 2) begin : g_bad_filt_len
        $error("ps2_rx: FILT_LEN must be at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("ps2_rx: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_clk_m;
    logic          r_clk_s;
    logic          r_dat_m;
    logic          r_dat_s;
    logic          r_clk_q;
    logic [2:0]    r_bit_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_shreg;
    logic          r_par;

    logic          w_clk_lvl;
    logic          w_fall;
    logic          w_data;
    logic          w_timeout;

    // Synchronisers reset to the idle (pulled-up) bus level so release of reset is not an edge.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_m <= 1'b1;
            r_clk_s <= 1'b1;
            r_dat_m <= 1'b1;
            r_dat_s <= 1'b1;
        end else begin
            r_clk_m <= PS2_CLK;
            r_clk_s <= r_clk_m;
            r_dat_m <= PS2_DATA;
            r_dat_s <= r_dat_m;
        end
    end

`ifdef PS2_RX_FILTER_EN
    localparam int FW = $clog2(FILT_LEN);

    logic          r_filt_lvl;
    logic [FW-1:0] r_filt_cnt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_lvl <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s == r_filt_lvl) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FW'(FILT_LEN - 1)) begin
            r_filt_lvl <= r_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
        end
    end

    assign w_clk_lvl = r_filt_lvl;
`else
    assign w_clk_lvl = r_clk_s;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_q <= 1'b1;
        end else begin
            r_clk_q <= w_clk_lvl;
        end
    end

    assign w_fall    = r_clk_q & ~w_clk_lvl;
    assign w_data    = r_dat_s;
    assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // Priority: inhibit, then a falling edge, then the inter-edge timeout.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rd_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (rx_inhibit) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
            end else if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
                if (w_fall && !w_data) begin
                    r_state <= S_DATA;
                end
            end else if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_DATA: begin
                        r_shreg   <= {w_data, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= w_data;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state   <= S_IDLE;
                        r_bit_cnt <= '0;
                        if (!w_data) begin
                            frame_err <= 1'b1;
                        end else if (^{r_shreg, r_par}) begin
                            rd_data  <= r_shreg;
                            rd_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
                frame_err <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    assign rx_busy   = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: device-model frames, error frames, timeout, inhibit, clock glitch and reset mid-frame.
module tb_ps2_rx;

    localparam int T    = 2000;
    localparam int HALF = 100;
    localparam int FL   = 8;
`ifdef PS2_RX_FILTER_EN
    localparam int LAT  = 3 + FL;
`else
    localparam int LAT  = 3;
`endif

    logic       clk_sys    = 1'b0;
    logic       rst_n      = 1'b0;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       rx_inhibit = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;
    logic [1:0] dbg_state;

    ps2_rx #(
        .TIMEOUT_CYC(T),
        .FILT_LEN   (FL)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .PS2_CLK   (ps2_clk),
        .PS2_DATA  (ps2_data),
        .rx_inhibit(rx_inhibit),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .rx_busy   (rx_busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #10 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: expected good bytes, popped on each rd_valid
    logic [7:0] exp_q[$];
    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;
    int t_valid = 0;
    int t_err   = 0;
    int t_fall  = 0;

    always @(negedge clk_sys) begin
        if (rd_valid === 1'b1) begin
            n_valid++;
            t_valid = cyc;
            if (exp_q.size() == 0) chk("unexpected_valid", 32'(exp_q.size()), 32'd1);
            else                   chk("rd_data_q", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        if (parity_err === 1'b1) begin
            n_perr++;
            t_err = cyc;
        end
        if (frame_err === 1'b1) begin
            n_ferr++;
            t_err = cyc;
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        t_fall  = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) ps2_bit(bits[i]);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stop,
                             input int ev, input int epe, input int efe, input logic [7:0] exp_data);
        int v0;
        int p0;
        int f0;
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
        if (ev != 0) exp_q.push_back(d);
        send_bits({stop, par, d, 1'b0}, 11);
        wait_cyc(LAT + 20);
        chk({tag, "_nvalid"}, 32'(n_valid - v0), 32'(ev));
        chk({tag, "_nperr"}, 32'(n_perr - p0), 32'(epe));
        chk({tag, "_nferr"}, 32'(n_ferr - f0), 32'(efe));
        chk({tag, "_rd_data"}, 32'(rd_data), 32'(exp_data));
        chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
        if (ev != 0) chk({tag, "_lat"}, 32'(t_valid - t_fall), 32'(LAT));
        else         chk({tag, "_lat"}, 32'(t_err - t_fall), 32'(LAT));
    endtask

    int v0;
    int p0;
    int f0;

    initial begin
        wait_cyc(5);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        run_frame("f1c", 8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C);
        run_frame("ff0", 8'hF0, 1'b0, 1'b1, 0, 1, 0, 8'h1C);
        run_frame("ffa", 8'hFA, 1'b1, 1'b0, 0, 0, 1, 8'h1C);
        run_frame("faa", 8'hAA, 1'b1, 1'b1, 1, 0, 0, 8'hAA);

        // start + 4 data bits, then the clock stays high
        v0 = n_valid;
        f0 = n_ferr;
        send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 5);
        wait_cyc(LAT + 2);
        chk("to_busy_mid", 32'(rx_busy), 32'd1);
        chk("to_state_mid", 32'(dbg_state), 32'd1);
        wait_cyc(T + 20);
        chk("to_nferr", 32'(n_ferr - f0), 32'd1);
        chk("to_lat", 32'(t_err - t_fall), 32'(LAT + T));
        chk("to_nvalid", 32'(n_valid - v0), 32'd0);
        chk("to_busy_after", 32'(rx_busy), 32'd0);
        run_frame("f55", 8'h55, 1'b1, 1'b1, 1, 0, 0, 8'h55);

        // inhibit after bit 3 of 0x12, including a start-like edge while inhibited
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
        send_bits({1'b1, 1'b1, 8'h12, 1'b0}, 5);
        wait_cyc(5);
        rx_inhibit = 1'b1;
        wait_cyc(5);
        chk("inh_busy", 32'(rx_busy), 32'd0);
        ps2_bit(1'b0);
        wait_cyc(LAT + 2);
        chk("inh_busy_edge", 32'(rx_busy), 32'd0);
        wait_cyc(T + 50);
        chk("inh_nvalid", 32'(n_valid - v0), 32'd0);
        chk("inh_nperr", 32'(n_perr - p0), 32'd0);
        chk("inh_nferr", 32'(n_ferr - f0), 32'd0);
        ps2_data   = 1'b1;
        rx_inhibit = 1'b0;
        wait_cyc(10);
        run_frame("f12", 8'h12, 1'b1, 1'b1, 1, 0, 0, 8'h12);

        // 3-cycle low glitch on idle clock with data high: no state change, no flag
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        wait_cyc(3);
        ps2_clk  = 1'b1;
        wait_cyc(LAT + 10);
        chk("gl1_state", 32'(dbg_state), 32'd0);
        chk("gl1_flags", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 32'd0);

        // same glitch with data low: taken as a start bit only without the filter
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        wait_cyc(3);
        ps2_clk  = 1'b1;
        wait_cyc(LAT + 10);
`ifdef PS2_RX_FILTER_EN
        chk("gl0_busy", 32'(rx_busy), 32'd0);
`else
        chk("gl0_busy", 32'(rx_busy), 32'd1);
`endif
        rx_inhibit = 1'b1;
        wait_cyc(2);
        rx_inhibit = 1'b0;
        ps2_data   = 1'b1;
        wait_cyc(2);
        chk("gl0_busy_clr", 32'(rx_busy), 32'd0);
        chk("gl0_flags", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 32'd0);

        // reset in the middle of a frame
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
        send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 6);
        wait_cyc(LAT + 2);
        chk("rmid_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        wait_cyc(2);
        chk("rmid_busy_rst", 32'(rx_busy), 32'd0);
        chk("rmid_data", 32'(rd_data), 32'd0);
        chk("rmid_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        wait_cyc(T + 20);
        chk("rmid_flags", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 32'd0);
        run_frame("f1c_b", 8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
